icache_refill_ctrl: RTL and testbench

Sequencer for the icache tag FIFO.
- Accepts one CPU fetch lookup at a time and drives the tag FIFO compare port.
- On a hit, returns the hit index.
- On a miss, invalidates the victim slot (the current write pointer), fetches the line from memory beat-by-beat into the data RAM, then commits the new tag with a tag write.
- Also sequences cache flush and keeps hit/miss counters.

---
 rtl/icache_refill_ctrl.sv | 159 +++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Icache miss sequencer: tag lookup, victim invalidate, line refill, tag commit, flush.
// Hit responds in the LOOKUP cycle, miss in COMMIT; req_ready only in IDLE with no flush pending.
module icache_refill_ctrl #(
  parameter int AW     = 32,
  parameter int OFFS_W = 5,
  parameter int DP     = 4,
  parameter int DW     = 32,
  parameter int BEATS  = 8,
  localparam int TAG_W = AW - OFFS_W,
  localparam int IW    = $clog2(DP),
  localparam int BW    = $clog2(BEATS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [IW-1:0]    rsp_idx,
  input  logic             flush_req,
  output logic             flush_done,
  output logic             tag_flush,
  output logic [TAG_W-1:0] tag_cmp_data,
  input  logic [DP-1:0]    tag_hit,
  input  logic [IW-1:0]    tag_hindex,
  input  logic [IW-1:0]    tag_wptr,
  output logic             tag_wr,
  output logic             tag_uwr,
  output logic [IW-1:0]    tag_uptr,
  output logic             tag_wvalid,
  output logic [TAG_W-1:0] tag_wtag,
  output logic             mem_req,
  output logic [AW-1:0]    mem_addr,
  input  logic             mem_ack,
  input  logic             mem_rvalid,
  input  logic [DW-1:0]    mem_rdata,
  output logic             dram_we,
  output logic [IW-1:0]    dram_idx,
  output logic [BW-1:0]    dram_beat,
  output logic [DW-1:0]    dram_wdata,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_INVAL, S_MREQ, S_REFILL, S_COMMIT, S_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_q;
  logic [IW-1:0]    vidx_q;
  logic [BW-1:0]    beat_q;
  logic             flush_blk_q;

  wire unused_offs = ^req_addr[OFFS_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tag_q       <= '0;
      vidx_q      <= '0;
      beat_q      <= '0;
      flush_blk_q <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid && req_ready)
        tag_q <= req_addr[AW-1:OFFS_W];
      if (state_q == S_LOOKUP) begin
        if (|tag_hit) begin
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          vidx_q <= tag_wptr;
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
      end
      if (state_q == S_REFILL && mem_rvalid)
        beat_q <= beat_q + 1'b1;
      // A held flush_req must drop for a cycle before it can trigger another flush.
      if (state_q == S_FLUSH)
        flush_blk_q <= 1'b1;
      else if (!flush_req)
        flush_blk_q <= 1'b0;
    end
  end

  assign tag_cmp_data = tag_q;
  assign mem_addr     = {tag_q, {OFFS_W{1'b0}}};
  assign dram_idx     = vidx_q;
  assign dram_beat    = beat_q;
  assign dram_wdata   = mem_rdata;

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_hit    = 1'b0;
    rsp_idx    = vidx_q;
    flush_done = 1'b0;
    tag_flush  = 1'b0;
    tag_wr     = 1'b0;
    tag_uwr    = 1'b0;
    tag_uptr   = vidx_q;
    tag_wvalid = 1'b0;
    tag_wtag   = '0;
    mem_req    = 1'b0;
    dram_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = !flush_req;
        if (flush_req) begin
          if (!flush_blk_q) state_d = S_FLUSH;
        end else if (req_valid) begin
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (|tag_hit) begin
          rsp_valid = 1'b1;
          rsp_hit   = 1'b1;
          rsp_idx   = tag_hindex;
          state_d   = S_IDLE;
        end else begin
          state_d = S_INVAL;
        end
      end
      S_INVAL: begin
        tag_uwr = 1'b1;
        state_d = S_MREQ;
      end
      S_MREQ: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = S_REFILL;
      end
      S_REFILL: begin
        if (mem_rvalid) begin
          dram_we = 1'b1;
          if (beat_q == BW'(BEATS - 1)) state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        tag_wr     = 1'b1;
        tag_wvalid = 1'b1;
        tag_wtag   = tag_q;
        rsp_valid  = 1'b1;
        state_d    = S_IDLE;
      end
      S_FLUSH: begin
        tag_flush  = 1'b1;
        flush_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Random-stimulus bench: tag FIFO and memory modelled here, responses checked against a line-level cache model.
module tb_icache_refill_ctrl;
  localparam int AW = 32, OFFS_W = 5, DP = 4, DW = 32, BEATS = 8;
  localparam int TAG_W = AW - OFFS_W, IW = $clog2(DP), BW = $clog2(BEATS);

  logic clk, reset_n;
  logic req_valid, req_ready, rsp_valid, rsp_hit, flush_req, flush_done, tag_flush;
  logic [AW-1:0] req_addr, mem_addr;
  logic [IW-1:0] rsp_idx, tag_hindex, tag_wptr, tag_uptr, dram_idx;
  logic [TAG_W-1:0] tag_cmp_data, tag_wtag;
  logic [DP-1:0] tag_hit;
  logic tag_wr, tag_uwr, tag_wvalid, mem_req, mem_ack, mem_rvalid, dram_we;
  logic [DW-1:0] mem_rdata, dram_wdata;
  logic [BW-1:0] dram_beat;
  logic [15:0] hit_cnt, miss_cnt;

  icache_refill_ctrl dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
    .flush_req(flush_req), .flush_done(flush_done), .tag_flush(tag_flush),
    .tag_cmp_data(tag_cmp_data), .tag_hit(tag_hit), .tag_hindex(tag_hindex),
    .tag_wptr(tag_wptr), .tag_wr(tag_wr), .tag_uwr(tag_uwr), .tag_uptr(tag_uptr),
    .tag_wvalid(tag_wvalid), .tag_wtag(tag_wtag), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dram_we(dram_we),
    .dram_idx(dram_idx), .dram_beat(dram_beat), .dram_wdata(dram_wdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag FIFO environment; unaffected by the controller's reset.
  logic [TAG_W-1:0] env_tag [DP];
  logic [DP-1:0]    env_v;
  logic [IW-1:0]    env_wptr;
  logic             env_clr;

  always @(posedge clk) begin
    if (env_clr || tag_flush) begin
      env_v    <= '0;
      env_wptr <= '0;
    end else begin
      if (tag_uwr) begin
        env_v[tag_uptr]   <= tag_wvalid;
        env_tag[tag_uptr] <= tag_wtag;
      end
      if (tag_wr) begin
        env_v[env_wptr]   <= tag_wvalid;
        env_tag[env_wptr] <= tag_wtag;
        env_wptr          <= env_wptr + 1'b1;
      end
    end
  end

  assign tag_wptr = env_wptr;

  always_comb begin
    tag_hit    = '0;
    tag_hindex = '0;
    for (int i = DP - 1; i >= 0; i--)
      if (env_v[i] && env_tag[i] == tag_cmp_data) begin
        tag_hit[i] = 1'b1;
        tag_hindex = IW'(i);
      end
  end

  // Line-level reference: resident lines in FIFO replacement order.
  logic [TAG_W-1:0] ref_line [DP];
  bit               ref_vld  [DP];
  int               ref_ptr, exp_hits, exp_miss;
  int               n_checks, n_errors;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic ref_flush();
    for (int i = 0; i < DP; i++) ref_vld[i] = 0;
    ref_ptr = 0;
  endtask

  // mode: 0 back-to-back beats, 1 beats every other cycle, 2 random gaps.
  // flush_at / rst_at: raise flush_req / assert reset once that many beats have landed (-1 = never).
  task automatic fetch(input logic [AW-1:0] addr, input int ack_dly, input int mode,
                       input int flush_at, input int rst_at);
    logic [TAG_W-1:0] line;
    logic [DW-1:0] d;
    bit exp_hit, acked, got, aborted, v;
    int exp_idx, cyc, mreq_n, rcyc, beats, uwr_n, wr_n, lat, n;
    line = addr[AW-1:OFFS_W];
    exp_hit = 0;
    exp_idx = ref_ptr;
    for (int i = 0; i < DP; i++)
      if (ref_vld[i] && ref_line[i] == line) begin
        exp_hit = 1;
        exp_idx = i;
      end
    acked = 0; got = 0; aborted = 0; d = '0;
    mreq_n = 0; rcyc = 0; beats = 0; uwr_n = 0; wr_n = 0; lat = 0; cyc = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    #1 check("req_ready", 64'(req_ready), 64'(1));
    while (!got && !aborted && cyc < 300) begin
      @(negedge clk);
      cyc++;
      req_valid  = 1'b0;
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      if (mem_req) begin
        mreq_n++;
        if (mreq_n == 1) check("mem_addr", 64'(mem_addr), 64'({line, {OFFS_W{1'b0}}}));
        if (mreq_n == ack_dly + 1) mem_ack = 1'b1;
      end else if (acked && beats < BEATS) begin
        if (beats == flush_at) flush_req = 1'b1;
        if (beats == rst_at) begin
          reset_n = 1'b0;
          #1;
          check("rst_pulses", 64'({mem_req, dram_we, rsp_valid, tag_wr, tag_uwr}), 64'(0));
          check("rst_ready", 64'(req_ready), 64'(1));
          check("rst_cnts", 64'({hit_cnt, miss_cnt}), 64'(0));
          aborted = 1;
        end else begin
          v = (mode == 0) ? 1'b1 : (mode == 1) ? (rcyc % 2 == 0) : 1'($urandom_range(0, 1));
          rcyc++;
          if (v) begin
            d = $urandom;
            mem_rvalid = 1'b1;
            mem_rdata  = d;
          end
        end
      end
      if (!aborted) begin
        #1;
        check("wr_uwr_excl", 64'(tag_wr & tag_uwr), 64'(0));
        if (cyc == 1) check("cmp_tag", 64'(tag_cmp_data), 64'(line));
        if (tag_uwr) begin
          uwr_n++;
          check("uwr", 64'({tag_uptr, tag_wvalid, tag_wtag}), 64'({IW'(exp_idx), 1'b0, TAG_W'(0)}));
          check("uwr_cyc", 64'(cyc), 64'(2));
        end
        if (tag_wr) begin
          wr_n++;
          check("wr", 64'({tag_wptr, tag_wvalid, tag_wtag}), 64'({IW'(exp_idx), 1'b1, line}));
        end
        if (flush_req) check("flush_held", 64'(tag_flush | flush_done), 64'(0));
        if (mem_rvalid) begin
          check("dram", 64'({dram_we, dram_idx, dram_beat, dram_wdata}),
                64'({1'b1, IW'(exp_idx), BW'(beats), d}));
          beats++;
        end else begin
          check("dram_idle", 64'(dram_we), 64'(0));
        end
        if (rsp_valid) begin
          got = 1;
          lat = cyc + 1;  // counts the accepting cycle as cycle 1
          check("rsp", 64'({rsp_hit, rsp_idx}), 64'({exp_hit, IW'(exp_idx)}));
        end
        if (mem_ack) acked = 1;
      end
    end
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    if (aborted) begin
      @(negedge clk);
      reset_n = 1'b1;
      ref_vld[exp_idx] = 0;
      exp_hits = 0;
      exp_miss = 0;
      check("rst_uwr_seen", 64'(uwr_n), 64'(1));
    end else begin
      check("rsp_seen", 64'(got), 64'(1));
      if (exp_hit) begin
        check("hit_lat", 64'(lat), 64'(2));
        check("hit_nomem", 64'({mreq_n, uwr_n, wr_n}), 64'(0));
        if (exp_hits < 65535) exp_hits++;
      end else begin
        check("miss_lat", 64'(lat), 64'(4 + mreq_n + rcyc));
        check("miss_ack", 64'(mreq_n), 64'(ack_dly + 1));
        check("miss_wr", 64'({uwr_n, wr_n, beats}), 64'({32'd1, 32'd1, 32'(BEATS)}));
        if (exp_miss < 65535) exp_miss++;
        ref_line[exp_idx] = line;
        ref_vld[exp_idx]  = 1;
        ref_ptr = (ref_ptr + 1) % DP;
      end
      @(negedge clk);
      n = 1;
      check("cnts", 64'({hit_cnt, miss_cnt}), 64'({16'(exp_hits), 16'(exp_miss)}));
      check("ready_after", 64'(req_ready), 64'(flush_at < 0));
      if (flush_at >= 0) begin
        while (!flush_done && n < 10) begin
          @(negedge clk);
          n++;
        end
        check("flush_after_fill", 64'({tag_flush, 32'(n)}), 64'({1'b1, 32'd2}));
        @(negedge clk);
        flush_req = 1'b0;
        ref_flush();
      end
    end
  endtask

  task automatic do_flush();
    int n;
    @(negedge clk);
    flush_req = 1'b1;
    #1 check("flush_blocks_req", 64'(req_ready), 64'(0));
    n = 0;
    while (!flush_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("flush_pulse", 64'({tag_flush, 32'(n)}), 64'({1'b1, 32'd1}));
    ref_flush();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_reflush", 64'({flush_done, tag_flush, req_ready}), 64'(0));
    end
    flush_req = 1'b0;
    @(negedge clk);
    #1 check("flush_release", 64'({flush_done, req_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    logic [AW-1:0] a;
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; env_clr = 1'b1;
    req_valid = 1'b0; req_addr = '0; flush_req = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    ref_flush();
    exp_hits = 0; exp_miss = 0;
    repeat (3) @(negedge clk);
    check("reset_pulses", 64'({rsp_valid, flush_done, tag_flush, tag_wr, tag_uwr, mem_req, dram_we}), 64'(0));
    check("reset_state", 64'({req_ready, hit_cnt, miss_cnt, tag_cmp_data, tag_uptr}), 64'({1'b1, 16'd0, 16'd0, TAG_W'(0), IW'(0)}));
    reset_n = 1'b1;
    env_clr = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(req_ready), 64'(1));

    fetch(32'h0000_1040, 2, 0, -1, -1);   // cold miss into slot 0
    fetch(32'h0000_1044, 0, 0, -1, -1);   // same line hits
    fetch(32'h0000_2000, 1, 2, -1, -1);
    fetch(32'h0000_3000, 0, 2, -1, -1);
    fetch(32'h0000_4000, 3, 2, -1, -1);
    fetch(32'h0000_5000, 0, 0, -1, -1);   // wraps onto slot 0
    fetch(32'h0000_1040, 0, 0, -1, -1);   // evicted line misses
    fetch(32'h0000_6000, 1, 1, -1, -1);   // gapped beats
    fetch(32'h0000_7000, 0, 0, 3, -1);    // flush raised mid-refill
    fetch(32'h0000_7000, 0, 0, -1, -1);
    do_flush();
    fetch(32'h0000_8000, 1, 0, -1, 4);    // reset mid-refill
    fetch(32'h0000_8000, 0, 0, -1, -1);   // no stale hit
    for (int i = 0; i < 40; i++) begin
      a = (32'($urandom_range(1, 6)) << 12) | 32'($urandom_range(0, 31));
      fetch(a, $urandom_range(0, 3), 2, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
